fir_filter: RTL and testbench



---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_round_sat.sv | 38 +++
 rtl/fir_filter.sv | 62 ++++++
 tb/tb_fir_filter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared widths, types, coefficient table and saturation limits
//                for the 8-tap symmetric Q4.12 FIR filter.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 12;
    localparam int TAPS   = 8;
    localparam int ACC_W  = 35;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [15:0]       coeff_t;

    // Linear-phase set: COEFFS[k] == COEFFS[TAPS-1-k], which the MAC pre-add relies on
    localparam coeff_t COEFFS [TAPS] = '{
        -16'sd344, -16'sd232, 16'sd748, 16'sd1674,
         16'sd1674, 16'sd748, -16'sd232, -16'sd344
    };

    localparam acc_t SAT_MAX = acc_t'((2 ** (DATA_W - 1)) - 1);
    localparam acc_t SAT_MIN = acc_t'(-(2 ** (DATA_W - 1)));

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_round_sat.sv
`default_nettype none
// ============================================================================
//  Module      : fir_round_sat
//  Description : Scales the Q.24 accumulator back to Q4.12 (floor, or
//                round-half-up when FIR_ROUND_EN is defined) and saturates.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_round_sat
    import fir_pkg::*;
(
    input  acc_t    acc,
    output sample_t y
);

    acc_t w_biased;
    acc_t w_shifted;

`ifdef FIR_ROUND_EN
    localparam acc_t ROUND_BIAS = acc_t'(2 ** (FRAC_W - 1));
    assign w_biased = acc + ROUND_BIAS;
`else
    assign w_biased = acc;
`endif

    // Arithmetic shift floors toward negative infinity
    assign w_shifted = w_biased >>> FRAC_W;

    always_comb begin
        y = sample_t'(w_shifted);
        if (w_shifted > SAT_MAX) begin
            y = sample_t'(SAT_MAX);
        end else if (w_shifted < SAT_MIN) begin
            y = sample_t'(SAT_MIN);
        end
    end

endmodule : fir_round_sat
`default_nettype wire

// File: rtl/fir_filter.sv
`default_nettype none
// ============================================================================
//  Module      : fir_filter
//  Description : 8-tap symmetric low-pass FIR, one Q4.12 sample per clock,
//                registered output. Optional rounding via FIR_ROUND_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_filter
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] x_in,
    output logic signed [DATA_W-1:0] y_out
);

    sample_t r_delay [TAPS];
    sample_t r_y;
    acc_t    w_pair  [TAPS/2];
    acc_t    w_prod  [TAPS/2];
    acc_t    w_acc;
    sample_t w_y_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                r_delay[k] <= '0;
            end
            r_y <= '0;
        end else begin
            r_delay[0] <= x_in;
            for (int k = 1; k < TAPS; k++) begin
                r_delay[k] <= r_delay[k-1];
            end
            r_y <= w_y_next;
        end
    end

    // Mirrored taps share a coefficient, so pre-add the pair and multiply once
    generate
        for (genvar k = 0; k < TAPS/2; k++) begin : g_preadd
            assign w_pair[k] = acc_t'(r_delay[k]) + acc_t'(r_delay[TAPS-1-k]);
            assign w_prod[k] = w_pair[k] * acc_t'(COEFFS[k]);
        end
    endgenerate

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < TAPS/2; k++) begin
            w_acc = w_acc + w_prod[k];
        end
    end

    fir_round_sat u_round_sat (
        .acc (w_acc),
        .y   (w_y_next)
    );

    assign y_out = r_y;

endmodule : fir_filter
`default_nettype wire

// File: tb/tb_fir_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_filter
//  Description : Self-checking bench for fir_filter against an arithmetic
//                sample-history model and a floating-point golden filter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_filter;

    logic               clk;
    logic               rst;
    logic signed [15:0] x_in;
    logic signed [15:0] y_out;

    int  COEF [8] = '{-344, -232, 748, 1674, 1674, 748, -232, -344};
    real H    [8] = '{-0.0841, -0.0567, 0.1826, 0.4086,
                       0.4086,  0.1826, -0.0567, -0.0841};

    // hist[k] holds x[n-1-k] relative to the next capturing edge
    int hist [8];
    int n_checks = 0;
    int n_errors = 0;

    fir_filter dut (
        .clk   (clk),
        .rst   (rst),
        .x_in  (x_in),
        .y_out (y_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int model_out();
        longint acc;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            acc += longint'(COEF[k]) * longint'(hist[k]);
        end
`ifdef FIR_ROUND_EN
        acc += 2048;
`endif
        acc = acc >>> 12;
        if (acc > 32767)       acc = 32767;
        else if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    function automatic real golden_out();
        real g;
        g = 0.0;
        for (int k = 0; k < 8; k++) begin
            g += H[k] * real'(hist[k]);
        end
        return g;
    endfunction

    task automatic clear_hist();
        for (int k = 0; k < 8; k++) hist[k] = 0;
    endtask

    // Drive one sample, advance one edge, compare y_out with the model
    task automatic run_sample(input int x, input string tag, input bit gold_chk);
        int  exp;
        real g;
        real d;
        exp = model_out();
        g   = golden_out();
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
        x_in = 16'(x);
        @(posedge clk);
        #1;
        check(tag, y_out, exp);
        if (gold_chk) begin
            d = real'(y_out) - g;
            if (d < 0.0) d = -d;
            check({tag, "_gold"}, (d <= 2.0) ? 1 : 0, 1);
        end
    endtask

    int imp_exp  [10] = '{0, -344, -232, 748, 1674, 1674, 748, -232, -344, 0};
    int step_exp [9]  = '{0, -344, -576, 172, 1846, 3520, 4268, 4036, 3692};
`ifdef FIR_ROUND_EN
    int trn_exp  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    int trn_exp  [10] = '{0, -1, -1, 0, 0, 0, 0, -1, -1, 0};
`endif
    int sat_seq  [8]  = '{-32768, -32768, 32767, 32767, 32767, 32767, -32768, -32768};
    int neg_seq  [8]  = '{32767, 32767, -32768, -32768, -32768, -32768, 32767, 32767};

    initial begin
        rst  = 1'b1;
        x_in = '0;
        clear_hist();
        repeat (2) @(posedge clk);
        #1;
        check("reset_y", y_out, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_sample((i == 0) ? 4096 : 0, "impulse_model", 1'b0);
            check("impulse_tbl", y_out, imp_exp[i]);
        end

        for (int i = 0; i < 10; i++) begin
            run_sample((i == 0) ? 1 : 0, "trunc_model", 1'b0);
            check("trunc_tbl", y_out, trn_exp[i]);
        end

        for (int i = 0; i < 12; i++) begin
            run_sample(4096, "step_model", 1'b0);
            check("step_tbl", y_out, (i < 9) ? step_exp[i] : 3692);
        end

        // Asynchronous reset between edges, then the step restarts from zero history
        rst = 1'b1;
        #2;
        check("async_rst_y", y_out, 0);
        #2;
        rst = 1'b0;
        clear_hist();
        for (int i = 0; i < 10; i++) begin
            run_sample(4096, "restep_model", 1'b0);
            check("restep_tbl", y_out, (i < 9) ? step_exp[i] : 3692);
        end

        for (int i = 0; i < 8; i++) run_sample(0, "flush_model", 1'b0);
        for (int i = 0; i < 8; i++) run_sample(sat_seq[i], "sat_pos_model", 1'b0);
        run_sample(neg_seq[0], "sat_pos_model", 1'b0);
        check("sat_pos", y_out, 32767);
        for (int i = 1; i < 8; i++) run_sample(neg_seq[i], "sat_neg_model", 1'b0);
        run_sample(0, "sat_neg_model", 1'b0);
        check("sat_neg", y_out, -32768);

        // Moderate-amplitude random stream, also held to the float golden filter
        for (int i = 0; i < 8; i++) run_sample(0, "flush_model", 1'b0);
        for (int i = 0; i < 256; i++) begin
            run_sample(int'($urandom_range(2048, 0)) - 1024, "rand_small", 1'b1);
        end

        // Full-range random stream, bit-exact only
        for (int i = 0; i < 64; i++) begin
            run_sample(int'($urandom_range(65535, 0)) - 32768, "rand_full", 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fir_filter
`default_nettype wire
